// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: bus widths, MMIO window
// base/offsets, the request payload and the byte-lane merge helper.
package sram_responder_pkg;

    localparam int unsigned ADDR_BUS_WIDTH = 32;
    localparam int unsigned DATA_BUS_WIDTH = 32;
    localparam int unsigned WE_BUS_WIDTH   = 4;
    localparam int unsigned LED_WIDTH      = 16;
    localparam int unsigned SWITCH_WIDTH   = 8;
    localparam int unsigned MMIO_OFS_WIDTH = 14;   // word offset inside the window

    localparam logic [15:0] MMIO_BASE_HI = 16'hBFAF;
    localparam logic [15:0] TIMER_OFS    = 16'h0000;
    localparam logic [15:0] LED_OFS      = 16'h0004;
    localparam logic [15:0] SWITCH_OFS   = 16'h0008;
    localparam logic [15:0] SCRATCH_OFS  = 16'h000C;

    // One SRAM-port request as seen in a single cycle
    typedef struct packed {
        logic [WE_BUS_WIDTH-1:0]   we;
        logic [ADDR_BUS_WIDTH-1:0] addr;
        logic [DATA_BUS_WIDTH-1:0] wdata;
    } sram_req_t;

    // Replace the byte lanes of old_word selected by we with new_word lanes
    function automatic logic [DATA_BUS_WIDTH-1:0] merge_lanes(
        input logic [DATA_BUS_WIDTH-1:0] old_word,
        input logic [DATA_BUS_WIDTH-1:0] new_word,
        input logic [WE_BUS_WIDTH-1:0]   we
    );
        logic [DATA_BUS_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < int'(WE_BUS_WIDTH); i++) begin
            if (we[i]) merged[8*i +: 8] = new_word[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_responder_mmio_regs.sv
// MMIO register window: free-running timer, LED, scratch, switch
// synchroniser and a registered read mux.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_en            access to the MMIO window this cycle
//   i_we            byte-lane write enables (0 = read)
//   i_ofs           word offset inside the window (byte offset [15:2])
//   i_wdata         write data
//   o_rdata         registered read data, updated only on an access
//   o_led           LED register
//   i_switch        asynchronous switch pins
module sram_responder_mmio_regs
    import sram_responder_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_en,
    input  logic [WE_BUS_WIDTH-1:0]   i_we,
    input  logic [MMIO_OFS_WIDTH-1:0] i_ofs,
    input  logic [DATA_BUS_WIDTH-1:0] i_wdata,
    output logic [DATA_BUS_WIDTH-1:0] o_rdata,
    output logic [LED_WIDTH-1:0]      o_led,
    input  logic [SWITCH_WIDTH-1:0]   i_switch
);

    logic [DATA_BUS_WIDTH-1:0] r_timer;
    logic [DATA_BUS_WIDTH-1:0] r_scratch;
    logic [LED_WIDTH-1:0]      r_led;
    logic [SWITCH_WIDTH-1:0]   r_sw_meta;
    logic [SWITCH_WIDTH-1:0]   r_sw_sync;
    logic [DATA_BUS_WIDTH-1:0] r_rdata;

    logic                      w_wr;
    logic [DATA_BUS_WIDTH-1:0] w_timer_next;
    logic [DATA_BUS_WIDTH-1:0] w_scratch_next;
    logic [LED_WIDTH-1:0]      w_led_next;
    logic [DATA_BUS_WIDTH-1:0] w_rd_mux;

    assign w_wr = i_en & (|i_we);

    // Next-state for the writable registers; a timer write beats the increment
    always_comb begin
        w_timer_next   = r_timer + 32'd1;
        w_scratch_next = r_scratch;
        w_led_next     = r_led;
        if (w_wr) begin
            if (i_ofs == TIMER_OFS[15:2]) begin
                w_timer_next = merge_lanes(r_timer, i_wdata, i_we);
            end
            if (i_ofs == SCRATCH_OFS[15:2]) begin
                w_scratch_next = merge_lanes(r_scratch, i_wdata, i_we);
            end
            if (i_ofs == LED_OFS[15:2]) begin
                if (i_we[0]) w_led_next[7:0]  = i_wdata[7:0];
                if (i_we[1]) w_led_next[15:8] = i_wdata[15:8];
            end
        end
    end

    // Read mux sees pre-update values (read-first)
    always_comb begin
        w_rd_mux = '0;
        case (i_ofs)
            TIMER_OFS[15:2]:   w_rd_mux = r_timer;
            LED_OFS[15:2]:     w_rd_mux = {16'h0, r_led};
            SWITCH_OFS[15:2]:  w_rd_mux = {24'h0, r_sw_sync};
            SCRATCH_OFS[15:2]: w_rd_mux = r_scratch;
            default:           w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer   <= '0;
            r_scratch <= '0;
            r_led     <= '0;
            r_sw_meta <= '0;
            r_sw_sync <= '0;
            r_rdata   <= '0;
        end else begin
            r_timer   <= w_timer_next;
            r_scratch <= w_scratch_next;
            r_led     <= w_led_next;
            r_sw_meta <= i_switch;
            r_sw_sync <= r_sw_meta;
            if (i_en) r_rdata <= w_rd_mux;
        end
    end

    assign o_rdata = r_rdata;
    assign o_led   = r_led;

endmodule

// File: rtl/sram_responder.sv
// Responder for the core's synchronous SRAM port: word-addressed RAM plus
// an MMIO register window, one-cycle registered read data.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   sram_en      access request this cycle
//   sram_we      byte-lane write enables (0 = read)
//   sram_addr    byte address, bits [1:0] ignored
//   sram_wdata   write data
//   sram_rdata   read data (old word on writes), valid after the request edge
//   led          LED register
//   switch       asynchronous switch pins
module sram_responder
    import sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [31:0] MMIO_BASE = {MMIO_BASE_HI, 16'h0000}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sram_en,
    input  logic [WE_BUS_WIDTH-1:0]   sram_we,
    input  logic [ADDR_BUS_WIDTH-1:0] sram_addr,
    input  logic [DATA_BUS_WIDTH-1:0] sram_wdata,
    output logic [DATA_BUS_WIDTH-1:0] sram_rdata,
    output logic [LED_WIDTH-1:0]      led,
    input  logic [SWITCH_WIDTH-1:0]   switch
);

    localparam int unsigned RAM_DEPTH = 1 << ADDR_W;

    logic [DATA_BUS_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_BUS_WIDTH-1:0] r_ram_rdata;
    logic                      r_mmio_sel;

    sram_req_t                 w_req;
    logic                      w_mmio_hit;
    logic                      w_ram_en;
    logic                      w_mmio_en;
    logic [ADDR_W-1:0]         w_ram_idx;
    logic [DATA_BUS_WIDTH-1:0] w_mmio_rdata;
    logic                      w_unused_addr;

    assign w_req      = '{we: sram_we, addr: sram_addr, wdata: sram_wdata};
    assign w_mmio_hit = (w_req.addr[31:16] == MMIO_BASE[31:16]);
    assign w_ram_en   = sram_en & ~w_mmio_hit;
    assign w_mmio_en  = sram_en & w_mmio_hit;
    // Upper index bits are dropped, so the RAM aliases across the address space
    assign w_ram_idx  = w_req.addr[ADDR_W+1:2];
    assign w_unused_addr = ^w_req.addr;

    // RAM byte-lane writes, blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (!reset && w_ram_en) begin
            for (int i = 0; i < int'(WE_BUS_WIDTH); i++) begin
                if (w_req.we[i]) r_mem[w_ram_idx][8*i +: 8] <= w_req.wdata[8*i +: 8];
            end
        end
    end

    // Read-first RAM data and the source select captured at the request edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ram_rdata <= '0;
            r_mmio_sel  <= 1'b0;
        end else if (sram_en) begin
            r_mmio_sel <= w_mmio_hit;
            if (w_ram_en) r_ram_rdata <= r_mem[w_ram_idx];
        end
    end

    sram_responder_mmio_regs u_mmio_regs (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_mmio_en),
        .i_we     (w_req.we),
        .i_ofs    (w_req.addr[15:2]),
        .i_wdata  (w_req.wdata),
        .o_rdata  (w_mmio_rdata),
        .o_led    (led),
        .i_switch (switch)
    );

    // Both sources are registered and hold while idle, so the output holds too
    assign sram_rdata = r_mmio_sel ? w_mmio_rdata : r_ram_rdata;

endmodule
